// File: rtl/key_display_register.sv
// Keypad-to-display register: decodes scanner row/column codes into a hex digit and multiplexes the last two keys onto a dual seven-segment display.
// Latency: a key sampled at edge N shows on digit_new/digit_old/new_key right after edge N; seg/an are combinational from registered state.
// Backpressure: none; enable is a level input and only one capture is taken per press, with re-arming on release.
// Optional build macro ANODE_BLANK_EN: blanks both anodes for the first 4 cycles of each digit slot to suppress ghosting.
module key_display_register #(
  parameter int MUX_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] rows,
  input  logic [3:0] columns,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       new_key,
  output logic       bad_code,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [3:0]          digit_new_q, digit_new_d;
  logic [3:0]          digit_old_q, digit_old_d;
  logic                new_key_q, new_key_d;
  logic                bad_code_q, bad_code_d;
  logic [MUX_BITS-1:0] refresh_q;
  logic                sel;

  logic [1:0] row_idx, col_idx;
  logic       row_ok, col_ok, code_ok;
  logic [3:0] key_val;

  // Row drive is one-hot active-high; row 1 is the MSB.
  always_comb begin
    row_idx = 2'd0;
    row_ok  = 1'b1;
    case (rows)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase
  end

  // Column sense is one-hot active-low; col 0 is the MSB.
  always_comb begin
    col_idx = 2'd0;
    col_ok  = 1'b1;
    case (columns)
      4'b0111: col_idx = 2'd0;
      4'b1011: col_idx = 2'd1;
      4'b1101: col_idx = 2'd2;
      4'b1110: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase
  end

  assign code_ok = row_ok & col_ok;

  // Keypad legend lookup: {row, col} -> hex value printed on the key.
  always_comb begin
    key_val = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: key_val = 4'h1;
      4'b00_01: key_val = 4'h2;
      4'b00_10: key_val = 4'h3;
      4'b00_11: key_val = 4'hA;
      4'b01_00: key_val = 4'h4;
      4'b01_01: key_val = 4'h5;
      4'b01_10: key_val = 4'h6;
      4'b01_11: key_val = 4'hB;
      4'b10_00: key_val = 4'h7;
      4'b10_01: key_val = 4'h8;
      4'b10_10: key_val = 4'h9;
      4'b10_11: key_val = 4'hC;
      4'b11_00: key_val = 4'hE;
      4'b11_01: key_val = 4'h0;
      4'b11_10: key_val = 4'hF;
      4'b11_11: key_val = 4'hD;
      default:  key_val = 4'h0;
    endcase
  end

  // Press FSM: capture once on a valid press, then wait for release before re-arming.
  always_comb begin
    state_d     = state_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    new_key_d   = 1'b0;
    bad_code_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        if (code_ok) begin
          digit_old_d = digit_new_q;
          digit_new_d = key_val;
          new_key_d   = 1'b1;
          state_d     = ST_HELD;
        end else begin
          // Stay idle so a code that settles later can still be captured.
          bad_code_d = 1'b1;
        end
      end
    end else begin
      if (!enable) state_d = ST_IDLE;
    end
  end

  // State, digit and pulse registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      new_key_q   <= 1'b0;
      bad_code_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      new_key_q   <= new_key_d;
      bad_code_q  <= bad_code_d;
    end
  end

  // Free-running refresh counter; its MSB picks which digit is lit.
  always_ff @(posedge clk) begin
    if (reset) refresh_q <= '0;
    else       refresh_q <= refresh_q + MUX_BITS'(1);
  end

  assign sel = refresh_q[MUX_BITS-1];

  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign new_key   = new_key_q;
  assign bad_code  = bad_code_q;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      4'hF: enc = 7'h0E;
      default: enc = 7'h7F;
    endcase
  endfunction

`ifdef ANODE_BLANK_EN
  logic       sel_prev_q;
  logic [1:0] blank_q;
  logic       sel_chg;

  assign sel_chg = sel ^ sel_prev_q;

  // Blank counter: reloads on a slot change so the first 4 cycles of each slot are dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_prev_q <= 1'b0;
      blank_q    <= 2'd0;
    end else begin
      sel_prev_q <= sel;
      if (sel_chg)             blank_q <= 2'd3;
      else if (blank_q != 2'd0) blank_q <= blank_q - 2'd1;
    end
  end

  // Segment/anode mux with both anodes off during the blank window.
  always_comb begin
    seg = sel ? enc(digit_old_q) : enc(digit_new_q);
    an  = sel ? 2'b01 : 2'b10;
    if (sel_chg || (blank_q != 2'd0)) an = 2'b11;
  end
`else
  // Segment/anode mux: right digit shows the newest key, left the previous one.
  always_comb begin
    seg = sel ? enc(digit_old_q) : enc(digit_new_q);
    an  = sel ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: tb/tb_key_display_register.sv
// Scoreboard bench for key_display_register: directed key presses push expected
// pulses into a queue; a negedge monitor pops and checks each new_key/bad_code pulse.
module tb_key_display_register;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] rows, columns;
  logic [3:0] digit_new, digit_old;
  logic       new_key, bad_code;
  logic [6:0] seg;
  logic [1:0] an;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cyc_rel = 0;

  typedef struct packed {
    logic        is_key;
    logic [3:0]  dn;
    logic [3:0]  dold;
    logic [31:0] at;
  } exp_t;

  exp_t exp_q[$];

  key_display_register #(.MUX_BITS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rows(rows), .columns(columns),
    .digit_new(digit_new), .digit_old(digit_old), .new_key(new_key),
    .bad_code(bad_code), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic is_key, input logic [3:0] dn, input logic [3:0] dold);
    exp_t e;
    e.is_key = is_key;
    e.dn     = dn;
    e.dold   = dold;
    e.at     = 32'(cyc + 1);
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected event, including its cycle.
  always @(negedge clk) begin
    if (new_key || bad_code) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: new_key=%0b bad_code=%0b dn=%0h do=%0h cycle %0d",
                 new_key, bad_code, digit_new, digit_old, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (new_key !== e.is_key || bad_code !== !e.is_key || digit_new !== e.dn ||
            digit_old !== e.dold || cyc != int'(e.at)) begin
          fails++;
          $display("FAIL pulse: got nk=%0b bc=%0b dn=%0h do=%0h cyc=%0d expected nk=%0b dn=%0h do=%0h cyc=%0d",
                   new_key, bad_code, digit_new, digit_old, cyc, e.is_key, e.dn, e.dold, e.at);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b1; enable = 1'b0; rows = 4'b0000; columns = 4'b1111;
    tick(2);
    chk("rst_digit_new", 32'(digit_new), 32'h0);
    chk("rst_digit_old", 32'(digit_old), 32'h0);
    chk("rst_new_key",   32'(new_key),   32'h0);
    chk("rst_bad_code",  32'(bad_code),  32'h0);
    chk("rst_an",        32'(an),        32'h2);
    chk("rst_seg",       32'(seg),       32'h40);

    // Idle display: counter starts at 0 on release, an toggles every 8 cycles.
    reset = 1'b0;
    cyc_rel = cyc;
    for (int i = 0; i < 16; i++) begin
      chk("idle_an",  32'(an),  (i < 8) ? 32'h2 : 32'h1);
      chk("idle_seg", 32'(seg), 32'h40);
      tick(1);
    end

    // Key 1 held 20 cycles, column changes mid-hold must be ignored.
    rows = 4'b1000; columns = 4'b0111; enable = 1'b1;
    push(1'b1, 4'h1, 4'h0);
    tick(5);
    columns = 4'b1011;
    tick(15);
    chk("held_dn", 32'(digit_new), 32'h1);
    chk("held_do", 32'(digit_old), 32'h0);
    enable = 1'b0;
    tick(3);

    // Key D: then display shows D on the right, 1 on the left.
    rows = 4'b0001; columns = 4'b1110; enable = 1'b1;
    push(1'b1, 4'hD, 4'h1);
    tick(3);
    enable = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      k = (cyc - cyc_rel) % 16;
      chk("disp_an",  32'(an),  (k < 8) ? 32'h2 : 32'h1);
      chk("disp_seg", 32'(seg), (k < 8) ? 32'h21 : 32'h79);
      tick(1);
    end

    // Invalid column code for one cycle: bad_code only, digits kept.
    rows = 4'b0100; columns = 4'b0011; enable = 1'b1;
    push(1'b0, 4'hD, 4'h1);
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("bad_dn", 32'(digit_new), 32'hD);
    chk("bad_do", 32'(digit_old), 32'h1);

    // Row 3 / col 1 -> 8.
    rows = 4'b0010; columns = 4'b1011; enable = 1'b1;
    push(1'b1, 4'h8, 4'hD);
    tick(2);
    enable = 1'b0;
    tick(2);

    // Key 6 with a one-cycle release in the middle counts as two presses.
    rows = 4'b0100; columns = 4'b1101; enable = 1'b1;
    push(1'b1, 4'h6, 4'h8);
    tick(3);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    push(1'b1, 4'h6, 4'h6);
    tick(2);
    enable = 1'b0;
    tick(2);

    // Reset while row 2 / col 0 is held: digits clear, then capture 4 on the next edge.
    rows = 4'b0100; columns = 4'b0111; enable = 1'b1; reset = 1'b1;
    tick(1);
    chk("midrst_dn", 32'(digit_new), 32'h0);
    chk("midrst_do", 32'(digit_old), 32'h0);
    chk("midrst_nk", 32'(new_key),   32'h0);
    reset = 1'b0;
    push(1'b1, 4'h4, 4'h0);
    tick(1);
    chk("post_rst_dn", 32'(digit_new), 32'h4);
    tick(5);
    enable = 1'b0;
    tick(3);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_display_register.md
Name: key_display_register

Overview:
- Downstream consumer of the keypad scanner.
- Accepts the scanner's `enable` (debounced key-held level) together with the active `rows`/`columns` code, and decodes it to a hex digit.
- Keeps the last two keys pressed: most recent on the right digit, previous on the left.
- Drives the time-multiplexed dual seven-segment display on the board.

Parameters:
- MUX_BITS, 18, width of the display refresh counter; the counter MSB selects the digit (sim uses 4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scanner key-valid level; high while a debounced key is held
- rows  in  4  scanner row drive, one-hot active-high; 4'b1000 = row 1 … 4'b0001 = row 4
- columns  in  4  column sense, one-hot active-low; 4'b0111 = col 0 … 4'b1110 = col 3
- digit_new  out  4  most recent key value
- digit_old  out  4  previous key value
- new_key  out  1  one-cycle pulse when a key is captured
- bad_code  out  1  one-cycle pulse when `enable` rises with an invalid row/column code
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- an  out  2  active-low anodes; an[0] = right digit, an[1] = left digit

Behaviour:
- Everything is sequential on the rising edge of `clk`. `reset` has priority over all other logic.

Reset values:
- state = IDLE
- digit_new = 0, digit_old = 0
- new_key = 0, bad_code = 0
- refresh counter = 0
- an = 2'b10, seg = pattern for 0 (7'h40)

Decode (row, col → value):
- row 1: 1, 2, 3, A
- row 2: 4, 5, 6, B
- row 3: 7, 8, 9, C
- row 4: E, 0, F, D
- A code is valid only if `rows` has exactly one bit set and `columns` has exactly one bit clear.

FSM, two states:
- IDLE:
  - `enable`=1 with a valid code → capture, go to HELD.
  - `enable`=1 with an invalid code → pulse `bad_code` next cycle, stay in IDLE, digits unchanged, re-evaluate every cycle.
- HELD:
  - Ignore `rows`/`columns`, including code changes and a second key in the same row.
  - `enable`=0 → IDLE.
  - No further capture until release. Exactly one capture per press regardless of hold length.

Capture:
- In the capturing cycle: digit_old ← digit_new and digit_new ← decoded value (registered).
- `new_key`=1 in the cycle after the sampling edge, for exactly 1 cycle.
- Latency: `enable` high at edge N → digits and `new_key` visible after edge N.
- `enable` dropping for 1 cycle and re-rising counts as a new press (upstream debounce owns glitch rejection).

Reset mid-operation:
- Any state returns to IDLE and digits clear.
- If `enable` is still high when reset deasserts, the next edge captures it as a new press.

Display:
- The refresh counter increments every cycle and wraps at 2^MUX_BITS. `sel` = counter MSB.
- sel=0: an=2'b10, seg=enc(digit_new).
- sel=1: an=2'b01, seg=enc(digit_old).
- `seg`/`an` are combinational from registered state; no glitch requirement beyond that.
- enc (hex 0–F, active-low): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.

Optional Feature:
- Macro: ANODE_BLANK_EN.
- Defined: a 2-bit blank counter reloads on every `sel` change. While it is nonzero, an=2'b11 (both off), so both anodes are off for the first 4 cycles of each digit slot, preventing ghosting. Reset loads the blank counter to 0.
- Undefined: no blanking; `an` follows `sel` immediately.
- Digit capture logic is identical either way.

Test Plan (MUX_BITS=4):
- Reset held 2 cycles, then released with enable=0 → digit_new=0, digit_old=0, new_key never pulses; `an` alternates 2'b10/2'b01 every 8 cycles with seg=7'h40.
- rows=4'b1000, columns=4'b0111, enable=1 for 20 cycles, then 0 → exactly one new_key pulse, one cycle after enable rises; digit_new=1, digit_old=0.
- Then rows=4'b0001, columns=4'b1110, enable pulse → digit_new=D, digit_old=1; when sel=0, seg=7'h21 and an=2'b10; when sel=1, seg=7'h79.
- While in HELD, change columns to 4'b1011 with enable still 1 → digits unchanged, no new_key.
- enable=1 with columns=4'b0011 → bad_code pulses 1 cycle, digits unchanged; then a valid row 3 / col 1 code → digit_new=8.
- Reset asserted for 1 cycle while holding row 2 / col 0 → digits become 0. The cycle after reset: digit_new=4, and new_key pulses once.
